// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART with ready/valid byte ports
module uart_transceiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t        tx_state, tx_state_next;
    logic [9:0]       tx_shift;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic             tx_bit_end, tx_frame_end;

    rx_state_t        rx_state, rx_state_next;
    logic [1:0]       rx_sync;
    logic             rx_line;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_mid_start, rx_mid_bit;

    assign tx_bit_end   = (tx_cnt == SYM_LAST);
    assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);
    // The shift register LSB is the line itself; filling with ones keeps it idle high.
    assign serial_out   = tx_shift[0];

    assign rx_line      = rx_sync[1];
    assign rx_mid_start = (rx_cnt == SAMPLE_LAST);
    assign rx_mid_bit   = (rx_cnt == SYM_LAST);

    // TX state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_next;
    end

    // TX next state; a byte is only accepted while idle
    always_comb begin
        tx_state_next = tx_state;
        data_in_ready = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                data_in_ready = 1'b1;
                if (data_in_valid) tx_state_next = TX_SEND;
            end
            TX_SEND: if (tx_frame_end) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX datapath: load {stop, data, start} on handshake, shift once per symbol
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (data_in_valid) tx_shift <= {1'b1, data_in, 1'b0};
                end
                TX_SEND: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= tx_bit + 4'd1;
                        tx_shift <= {1'b1, tx_shift[9:1]};
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_cnt <= '0;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous RX line, reset to idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], serial_in};
    end

    // RX state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_next;
    end

    // RX next state; no new frame is started while the one-byte buffer is full
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_line && !data_out_valid) rx_state_next = RX_START;
            RX_START:     if (rx_mid_start) rx_state_next = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_mid_bit && (rx_bit == 3'd7)) rx_state_next = RX_STOP;
            RX_STOP:      if (rx_mid_bit) rx_state_next = rx_line ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_line) rx_state_next = RX_IDLE;
            default:      rx_state_next = RX_IDLE;
        endcase
    end

    // RX datapath: half-symbol wait to centre on the start bit, then full symbols
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_START: rx_cnt <= rx_mid_start ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_mid_bit) begin
                        rx_cnt   <= '0;
                        rx_bit   <= rx_bit + 3'd1;
                        rx_shift <= {rx_line, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= rx_mid_bit ? '0 : rx_cnt + 1'b1;
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // Output buffer: filled on a good stop bit, emptied by the consumer handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
        end else if ((rx_state == RX_STOP) && rx_mid_bit && rx_line) begin
            data_out       <= rx_shift;
            data_out_valid <= 1'b1;
        end else if (data_out_valid && data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - loopback pair bench for uart_transceiver
module tb_uart_transceiver;
    localparam int CF   = 3_300_000;
    localparam int BR   = 100_000;
    localparam int SYM  = 33;
    localparam int HALF = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_din = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] a_dout;
    logic       a_dvalid;
    logic       a_dready = 1'b1;
    logic       a_so;
    logic [7:0] b_din = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready_unused;
    logic [7:0] b_dout;
    logic       b_dvalid;
    logic       b_ready = 1'b0;
    logic       b_so;
    logic       b_si;
    logic       force_en = 1'b0;
    logic       force_val = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int hs_cyc = 0;
    int b_rise_cyc = 0;
    logic b_prev = 1'b0;
    logic [7:0] exp_q[$];

    assign b_si = force_en ? force_val : a_so;

    uart_transceiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) u_a (
        .clk(clk), .reset(reset),
        .data_in(a_din), .data_in_valid(a_valid), .data_in_ready(a_ready),
        .data_out(a_dout), .data_out_valid(a_dvalid), .data_out_ready(a_dready),
        .serial_in(b_so), .serial_out(a_so)
    );

    uart_transceiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) u_b (
        .clk(clk), .reset(reset),
        .data_in(b_din), .data_in_valid(b_valid), .data_in_ready(b_ready_unused),
        .data_out(b_dout), .data_out_valid(b_dvalid), .data_out_ready(b_ready),
        .serial_in(b_si), .serial_out(b_so)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(negedge clk) begin
        if (b_dvalid && !b_prev) b_rise_cyc <= ncyc;
        b_prev <= b_dvalid;
    end

    // Offers d on A; returns at the first negedge after the handshake edge.
    task automatic send_a(input logic [7:0] d, input bit push, output bit ok);
        a_din = d;
        a_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 * SYM; i++) begin
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        a_valid = 1'b0;
        hs_cyc = ncyc;
        if (ok && push) exp_q.push_back(d);
    endtask

    task automatic wait_b_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (b_dvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_a_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 * SYM; i++) begin
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_b();
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vectors++; if (a_so !== 1'b1)     begin miscompares++; $display("FAIL reset_serial_out got %b want 1", a_so); end
        vectors++; if (a_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_ready got %b want 1", a_ready); end
        vectors++; if (b_dvalid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", b_dvalid); end
        vectors++; if (b_dout !== 8'h00)  begin miscompares++; $display("FAIL reset_data_out got %h want 00", b_dout); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        bit ok, seen;
        int low_cycles, lat;
        logic [7:0] exp;
        b_ready = 1'b0;
        send_a(8'h7A, 1'b1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL loop_handshake timed out"); end
        low_cycles = 0;
        while (!a_ready && low_cycles < 20 * SYM) begin
            low_cycles++;
            @(negedge clk);
        end
        vectors++; if (low_cycles != 10 * SYM) begin miscompares++; $display("FAIL loop_ready_low got %0d want %0d", low_cycles, 10 * SYM); end
        wait_b_valid(20 * SYM, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL loop_rx_valid timed out"); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (b_dout !== exp) begin miscompares++; $display("FAIL loop_rx_data got %h want %h", b_dout, exp); end
        lat = b_rise_cyc - hs_cyc;
        vectors++; if (lat < 9 * SYM + HALF - 3 || lat > 9 * SYM + HALF + 3)
            begin miscompares++; $display("FAIL loop_rx_latency got %0d want about %0d", lat, 9 * SYM + HALF + 2); end
        vectors++; if (b_dvalid !== 1'b1) begin miscompares++; $display("FAIL loop_hold_valid got %b want 1", b_dvalid); end
        ack_b();
        vectors++; if (b_dvalid !== 1'b0) begin miscompares++; $display("FAIL loop_ack_clear got %b want 0", b_dvalid); end
    endtask

    task automatic test_tx_bits();
        bit ok, bad, seen;
        logic [9:0] frame;
        logic [7:0] exp;
        frame = {1'b1, 8'hA5, 1'b0};
        vectors++; if (a_so !== 1'b1) begin miscompares++; $display("FAIL txbits_idle_before got %b want 1", a_so); end
        send_a(8'hA5, 1'b1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL txbits_handshake timed out"); end
        for (int i = 0; i < 10; i++) begin
            bad = 1'b0;
            for (int c = 0; c < SYM; c++) begin
                if (a_so !== frame[i]) bad = 1'b1;
                @(negedge clk);
            end
            vectors++; if (bad) begin miscompares++; $display("FAIL txbits_bit%0d line not held at %b for %0d cycles", i, frame[i], SYM); end
        end
        vectors++; if (a_so !== 1'b1) begin miscompares++; $display("FAIL txbits_idle_after got %b want 1", a_so); end
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL txbits_rx got %h valid %b want %h", b_dout, seen, exp); end
        ack_b();
    endtask

    task automatic test_back_to_back();
        bit ok;
        b_ready = 1'b1;
        fork
            begin
                int low_cycles;
                a_din = 8'h00;
                a_valid = 1'b1;
                wait_a_idle(ok);
                @(negedge clk);
                if (ok) exp_q.push_back(8'h00);
                a_din = 8'hFF;
                low_cycles = 0;
                while (!a_ready && low_cycles < 20 * SYM) begin
                    low_cycles++;
                    @(negedge clk);
                end
                vectors++; if (low_cycles != 10 * SYM) begin miscompares++; $display("FAIL b2b_ready_low got %0d want %0d", low_cycles, 10 * SYM); end
                vectors++; if (a_so !== 1'b1) begin miscompares++; $display("FAIL b2b_stop_bit got %b want 1", a_so); end
                @(negedge clk);
                exp_q.push_back(8'hFF);
                a_valid = 1'b0;
                vectors++; if (a_so !== 1'b0) begin miscompares++; $display("FAIL b2b_next_start got %b want 0", a_so); end
            end
            begin
                bit seen;
                logic [7:0] exp;
                for (int k = 0; k < 2; k++) begin
                    wait_b_valid(30 * SYM, seen);
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL b2b_rx%0d got %h valid %b want %h", k, b_dout, seen, exp); end
                    @(negedge clk);
                end
            end
        join
        b_ready = 1'b0;
        wait_a_idle(ok);
        repeat (SYM) @(negedge clk);
    endtask

    task automatic test_unconsumed();
        bit ok, seen;
        logic [7:0] exp;
        b_ready = 1'b0;
        send_a(8'h11, 1'b1, ok);
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL hold_first got %h valid %b want %h", b_dout, seen, exp); end
        wait_a_idle(ok);
        send_a(8'h22, 1'b0, ok);
        wait_a_idle(ok);
        repeat (2 * SYM) @(negedge clk);
        vectors++; if (b_dvalid !== 1'b1 || b_dout !== 8'h11)
            begin miscompares++; $display("FAIL hold_lost_byte got %h valid %b want 11 valid 1", b_dout, b_dvalid); end
        ack_b();
        vectors++; if (b_dvalid !== 1'b0) begin miscompares++; $display("FAIL hold_ack got %b want 0", b_dvalid); end
        send_a(8'h33, 1'b1, ok);
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL hold_next got %h valid %b want %h", b_dout, seen, exp); end
        ack_b();
        wait_a_idle(ok);
    endtask

    task automatic test_glitch_framing();
        bit ok, seen, any;
        logic [9:0] bad_frame;
        logic [7:0] exp;
        force_val = 1'b1;
        force_en = 1'b1;
        @(negedge clk);
        force_val = 1'b0;
        repeat (SYM / 5) @(negedge clk);
        force_val = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 12 * SYM; i++) begin
            if (b_dvalid) any = 1'b1;
            @(negedge clk);
        end
        vectors++; if (any) begin miscompares++; $display("FAIL glitch_valid got 1 want 0"); end
        bad_frame = {1'b0, 8'hE7, 1'b0};
        any = 1'b0;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < SYM; c++) begin
                force_val = (i < 10) ? bad_frame[i] : 1'b0;
                if (b_dvalid) any = 1'b1;
                @(negedge clk);
            end
        end
        force_val = 1'b1;
        for (int i = 0; i < 2 * SYM; i++) begin
            if (b_dvalid) any = 1'b1;
            @(negedge clk);
        end
        vectors++; if (any) begin miscompares++; $display("FAIL framing_valid got 1 want 0"); end
        force_en = 1'b0;
        repeat (SYM) @(negedge clk);
        send_a(8'h5C, 1'b1, ok);
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL framing_recover got %h valid %b want %h", b_dout, seen, exp); end
        ack_b();
        wait_a_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic [7:0] exp;
        b_ready = 1'b0;
        send_a(8'h7A, 1'b1, ok);
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL rstmid_prefill got %h valid %b want %h", b_dout, seen, exp); end
        wait_a_idle(ok);
        send_a(8'h7A, 1'b0, ok);
        repeat (3 * SYM + HALF) @(negedge clk);
        vectors++; if (a_so !== 1'b0 || a_ready !== 1'b0)
            begin miscompares++; $display("FAIL rstmid_busy got line %b ready %b want 0 0", a_so, a_ready); end
        reset = 1'b0;
        #1;
        vectors++; if (a_so !== 1'b1)     begin miscompares++; $display("FAIL rstmid_serial_out got %b want 1", a_so); end
        vectors++; if (a_ready !== 1'b1)  begin miscompares++; $display("FAIL rstmid_ready got %b want 1", a_ready); end
        vectors++; if (b_dvalid !== 1'b0 || b_dout !== 8'h00)
            begin miscompares++; $display("FAIL rstmid_rx got %h valid %b want 00 valid 0", b_dout, b_dvalid); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_a(8'h7A, 1'b1, ok);
        wait_b_valid(20 * SYM, seen);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (!seen || b_dout !== exp) begin miscompares++; $display("FAIL rstmid_fresh got %h valid %b want %h", b_dout, seen, exp); end
        ack_b();
        wait_a_idle(ok);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tx_bits();
        test_back_to_back();
        test_unconsumed();
        test_glitch_framing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART with ready/valid byte interfaces on both directions.
- One instance sits on-chip behind the CPU's memory-mapped I/O (status, receive-data and transmit-data registers).
- A second instance serves as the off-chip host model in integration benches, cross-wired serial_out to serial_in.

Parameters:
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- Derived, not overridable: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer divide; 1085 at defaults). SAMPLE_TIME = SYMBOL_EDGE_TIME / 2. Counter width = clog2(SYMBOL_EDGE_TIME).

Ports:
- clk, input, 1: single system clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-low reset; asserted when 0.
- data_in, input, 8: byte to transmit.
- data_in_valid, input, 1: data_in is valid.
- data_in_ready, output, 1: transmitter can accept a byte.
- data_out, output, 8: last received byte.
- data_out_valid, output, 1: data_out holds an unconsumed byte.
- data_out_ready, input, 1: consumer takes data_out.
- serial_in, input, 1: asynchronous RX line, idle high.
- serial_out, output, 1: TX line, idle high; registered output.

Behaviour:
- Reset (reset=0, takes effect immediately, no clk edge needed):
  - serial_out=1, data_in_ready=1, data_out_valid=0, data_out=8'h00.
  - All counters cleared; both FSMs go to IDLE.
  - Reset mid-frame aborts the frame. serial_out returns high at once, no partial stop bit. A partial RX frame is discarded.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly SYMBOL_EDGE_TIME cycles.
- Transmitter FSM (IDLE -> SEND):
  - IDLE: data_in_ready=1, serial_out=1.
  - Handshake = data_in_valid & data_in_ready at a rising edge. On it, latch data_in into a 10-bit shift register {1, data, 0}, go to SEND, deassert data_in_ready.
  - SEND: serial_out shows the start bit from the cycle after the handshake. Shift every SYMBOL_EDGE_TIME cycles.
  - After the stop bit has been driven for its full SYMBOL_EDGE_TIME cycles, return to IDLE; data_in_ready=1 on that edge.
  - Total ready-low time = 10*SYMBOL_EDGE_TIME cycles.
  - data_in_valid while busy is ignored and the byte is not captured. data_in changes after the handshake do not affect the frame.
  - Back-to-back: valid held high across the return to IDLE starts the next frame on the first ready cycle; no extra idle bit is required.
- Receiver FSM (IDLE -> START -> DATA -> STOP):
  - serial_in passes through a 2-flop synchronizer. All RX latencies below are counted from the synchronized signal, which lags serial_in by 2 cycles.
  - IDLE: wait for synchronized serial_in=0. Starting a frame is suppressed while data_out_valid=1; a frame arriving then is lost.
  - START: at SAMPLE_TIME cycles, sample the line. If 1 (glitch), go back to IDLE with no output. If 0, go to DATA.
  - DATA: sample each bit at mid-bit, i.e. every SYMBOL_EDGE_TIME cycles after the start-bit sample. Shift in LSB first.
  - STOP: sample at mid stop bit. If 1: data_out <= received byte, data_out_valid <= 1, go to IDLE. If 0 (framing error): discard the byte, flags unchanged; wait for the line to return to 1, then go to IDLE.
  - data_out_valid is set about 9.5 symbols + 2 cycles after the falling edge of serial_in.
  - Timing: data_out_valid holds until data_out_valid & data_out_ready at an edge, then clears next cycle. data_out is stable while valid.
  - data_out_ready while data_out_valid=0 has no effect.
- TX and RX are fully independent. Simultaneous handshakes on both sides in one cycle are both honoured.
- No parity, no break detection, no FIFO; the RX buffer is one byte deep.

Test Plan:
- Loopback pair (A.serial_out->B.serial_in and B->A), reset pulse, then A sends 8'h7A with 1-cycle valid:
  - A.data_in_ready low for 10*1085 cycles.
  - B.data_out=8'h7A with B.data_out_valid=1 about 10300 cycles later.
  - B.data_out_valid clears 1 cycle after a 1-cycle B.data_out_ready pulse.
- Bit-exact TX of 8'hA5:
  - serial_out = 0,1,0,1,0,0,1,0,1,1, each level lasting exactly 1085 cycles.
  - serial_out=1 before and after the frame.
- Back-to-back, valid held through 8'h00 then 8'hFF:
  - Second start bit immediately follows the first stop bit.
  - Receiver delivers 00 then FF, with the consumer acking each byte.
- Unconsumed byte: send 8'h11, leave data_out_ready=0, send 8'h22:
  - data_out stays 8'h11 with valid=1; 8'h22 is lost.
  - After the ack, a new 8'h33 is received correctly.
- Glitch and framing error:
  - A 200-cycle low pulse on serial_in gives no data_out_valid.
  - A frame with stop bit 0 gives no data_out_valid; the next good frame 8'h5C is received.
- Reset mid-operation: pull reset=0 halfway through a TX frame:
  - serial_out=1 and data_in_ready=1 immediately; RX valid=0.
  - After release, a fresh 8'h7A transfers correctly.
